uart_rxd: RTL



---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rxd.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and baud divider math
// common to the uart_rxd / uart_txd pair.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clocks per bit; integer division, so the link tolerates the truncation error.
    function automatic int baud_div(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

    function automatic int baud_half(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; reset value
// chosen by the instantiator so the output matches the line's idle level.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rxd.sv
// UART receiver: 8 data bits MSB first, one stop bit. Samples the synchronised
// line at bit centres and strobes valid (good frame) or frame_err (stop low).
module uart_rxd
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115_200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] q,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    // DIV below 4 is unsupported: HALF-1 would not leave room for the start check.
    localparam int DIV  = baud_div(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int HALF = baud_half(DIV);
    localparam int CW   = $clog2(DIV);
    localparam int BW   = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [BW-1:0]          bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]   shift_reg, shift_n;
    logic [7:0]             q_n;
    logic                   valid_n, frame_err_n;
    logic                   rx_s;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            q         <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_n;
            q         <= q_n;
            valid     <= valid_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        bit_cnt_n   = bit_cnt;
        shift_n     = shift_reg;
        q_n         = q;
        valid_n     = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == CNT_MID) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = DATA;
                        bit_cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    shift_n   = {shift_reg[DATA_BITS-2:0], rx_s};
                    bit_cnt_n = bit_cnt + BW'(1);
                    if (bit_cnt == BW'(DATA_BITS - 1)) begin
                        state_n = STOP;
                        cnt_n   = '0;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        q_n     = shift_reg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end
            end
            BREAK: begin
                // Held-low line must return high before another start is armed.
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
